// File: rtl/phold_core.sv
// rtl/phold_core.sv - single-core PHOLD event engine: loads LP timestamps, processes min event, logs it, reports GVT
module phold_core #(
  parameter int NUM_MC_PORTS = 1,
  parameter int RTNCTL_WIDTH = 32,
  parameter int NUM_LP       = 8,
  parameter int END_TIME     = 1000,
  parameter int LOG_DEPTH    = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [47:0]                          addr,
  output logic [13:0]                          gvt,
  output logic                                 rtn_vld,
  output logic [NUM_MC_PORTS-1:0]              mc_rq_vld,
  output logic [3*NUM_MC_PORTS-1:0]            mc_rq_cmd,
  output logic [4*NUM_MC_PORTS-1:0]            mc_rq_scmd,
  output logic [48*NUM_MC_PORTS-1:0]           mc_rq_vadr,
  output logic [2*NUM_MC_PORTS-1:0]            mc_rq_size,
  output logic [RTNCTL_WIDTH*NUM_MC_PORTS-1:0] mc_rq_rtnctl,
  output logic [64*NUM_MC_PORTS-1:0]           mc_rq_data,
  output logic [NUM_MC_PORTS-1:0]              mc_rq_flush,
  input  logic [NUM_MC_PORTS-1:0]              mc_rq_stall,
  input  logic [NUM_MC_PORTS-1:0]              mc_rs_vld,
  input  logic [3*NUM_MC_PORTS-1:0]            mc_rs_cmd,
  input  logic [4*NUM_MC_PORTS-1:0]            mc_rs_scmd,
  input  logic [RTNCTL_WIDTH*NUM_MC_PORTS-1:0] mc_rs_rtnctl,
  input  logic [64*NUM_MC_PORTS-1:0]           mc_rs_data,
  output logic [NUM_MC_PORTS-1:0]              mc_rs_stall
);

  localparam int IW = $clog2(NUM_LP);
  localparam int CW = IW + 1;
  localparam int LW = $clog2(LOG_DEPTH);
  localparam logic [2:0] CMD_RD = 3'd1, CMD_WR = 3'd2, RS_RD_DATA = 3'd2, RS_WR_CMP = 3'd3;

  typedef enum logic [2:0] {S_INIT_RD, S_INIT_WAIT, S_SELECT, S_WRITE, S_WAIT_WC, S_DONE} state_t;

  state_t      state_q;
  logic [13:0] slot_q [NUM_LP];
  logic [NUM_LP-1:0] issued_q, ret_q;
  logic [CW-1:0] rd_cnt_q;
  logic [31:0] evcnt_q;
  logic [15:0] lfsr_q;
  logic [13:0] gvt_q, ts_q;
  logic [IW-1:0] lp_q, rq_rtnctl_q;
  logic        rtn_vld_q, rq_vld_q;
  logic [2:0]  rq_cmd_q;
  logic [47:0] rq_vadr_q;
  logic [63:0] rq_data_q;

  logic [13:0] min_ts_d, next_ts_d;
  logic [IW-1:0] min_idx_d;
  logic [14:0] sum_d;
  logic [15:0] lfsr_d;
  logic        accept, rs_vld, rs_in_range, rd_ok, wc_ok;
  logic [IW-1:0] rs_idx;
  logic        unused_in;

  // Strict '<' keeps the lowest index on ties.
  always_comb begin
    min_ts_d  = slot_q[0];
    min_idx_d = '0;
    for (int i = 1; i < NUM_LP; i++) begin
      if (slot_q[i] < min_ts_d) begin
        min_ts_d  = slot_q[i];
        min_idx_d = IW'(i);
      end
    end
  end

  assign sum_d     = {1'b0, ts_q} + 15'd1 + {11'd0, lfsr_q[3:0]};
  assign next_ts_d = sum_d[14] ? 14'h3FFF : sum_d[13:0];
  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign accept      = rq_vld_q && !mc_rq_stall[0];
  assign rs_vld      = mc_rs_vld[0];
  assign rs_idx      = mc_rs_rtnctl[IW-1:0];
  assign rs_in_range = mc_rs_rtnctl[RTNCTL_WIDTH-1:0] < RTNCTL_WIDTH'(NUM_LP);
  // Only reads this run actually issued may fill a slot, so stale data from before a reset is dropped.
  assign rd_ok = rs_vld && (mc_rs_cmd[2:0] == RS_RD_DATA) && rs_in_range &&
                 issued_q[rs_idx] && !ret_q[rs_idx] &&
                 ((state_q == S_INIT_RD) || (state_q == S_INIT_WAIT));
  assign wc_ok = rs_vld && (mc_rs_cmd[2:0] == RS_WR_CMP) && (state_q == S_WAIT_WC);
  assign unused_in = ^{mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data, evcnt_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT_RD;
      for (int i = 0; i < NUM_LP; i++) slot_q[i] <= '0;
      issued_q    <= '0;
      ret_q       <= '0;
      rd_cnt_q    <= '0;
      evcnt_q     <= '0;
      lfsr_q      <= 16'hACE1;
      gvt_q       <= '0;
      ts_q        <= '0;
      lp_q        <= '0;
      rtn_vld_q   <= 1'b0;
      rq_vld_q    <= 1'b0;
      rq_cmd_q    <= '0;
      rq_vadr_q   <= '0;
      rq_rtnctl_q <= '0;
      rq_data_q   <= '0;
    end else begin
      case (state_q)
        S_INIT_RD: begin
          if (accept) issued_q[rq_rtnctl_q] <= 1'b1;
          if (!rq_vld_q || accept) begin
            if (rd_cnt_q < CW'(NUM_LP)) begin
              rq_vld_q    <= 1'b1;
              rq_cmd_q    <= CMD_RD;
              rq_vadr_q   <= addr + 48'({rd_cnt_q, 3'b000});
              rq_rtnctl_q <= rd_cnt_q[IW-1:0];
              rq_data_q   <= '0;
              rd_cnt_q    <= rd_cnt_q + 1'b1;
            end else begin
              rq_vld_q <= 1'b0;
              state_q  <= S_INIT_WAIT;
            end
          end
        end
        S_INIT_WAIT: if (&ret_q) state_q <= S_SELECT;
        S_SELECT: begin
          gvt_q <= min_ts_d;
          if (min_ts_d >= 14'(END_TIME)) begin
            rtn_vld_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            ts_q        <= min_ts_d;
            lp_q        <= min_idx_d;
            rq_vld_q    <= 1'b1;
            rq_cmd_q    <= CMD_WR;
            rq_vadr_q   <= addr + 48'(8 * NUM_LP) + 48'({evcnt_q[LW-1:0], 3'b000});
            rq_rtnctl_q <= '0;
            rq_data_q   <= {32'd0, 12'd0, 4'(min_idx_d), 2'b00, min_ts_d};
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (accept) begin
            slot_q[lp_q] <= next_ts_d;
            lfsr_q       <= lfsr_d;
            evcnt_q      <= evcnt_q + 1'b1;
            rq_vld_q     <= 1'b0;
            state_q      <= S_WAIT_WC;
          end
        end
        S_WAIT_WC: if (wc_ok) state_q <= S_SELECT;
        S_DONE: ;
        default: state_q <= S_INIT_RD;
      endcase
      if (rd_ok) begin
        slot_q[rs_idx] <= mc_rs_data[13:0];
        ret_q[rs_idx]  <= 1'b1;
      end
    end
  end

  assign gvt         = gvt_q;
  assign rtn_vld     = rtn_vld_q;
  assign mc_rs_stall = '0;

  always_comb begin
    mc_rq_vld    = '0;
    mc_rq_cmd    = '0;
    mc_rq_scmd   = '0;
    mc_rq_vadr   = '0;
    mc_rq_size   = '0;
    mc_rq_rtnctl = '0;
    mc_rq_data   = '0;
    mc_rq_flush  = '0;
    mc_rq_vld[0]                     = rq_vld_q;
    mc_rq_cmd[2:0]                   = rq_cmd_q;
    mc_rq_vadr[47:0]                 = rq_vadr_q;
    mc_rq_size[1:0]                  = 2'd3;
    mc_rq_rtnctl[RTNCTL_WIDTH-1:0]   = RTNCTL_WIDTH'(rq_rtnctl_q);
    mc_rq_data[63:0]                 = rq_data_q;
  end

endmodule

// File: tb/tb_phold_core.sv
// tb/tb_phold_core.sv - randomized memory responder with an event-list reference model for phold_core
module tb_phold_core;
  localparam int N = 8;
  localparam int END_T = 1000;
  localparam logic [47:0] BASE = 48'h0000_1234_5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [47:0] addr;
  logic [13:0] gvt;
  logic        rtn_vld;
  logic [0:0]  mc_rq_vld, mc_rq_flush, mc_rq_stall, mc_rs_vld, mc_rs_stall;
  logic [2:0]  mc_rq_cmd, mc_rs_cmd;
  logic [3:0]  mc_rq_scmd, mc_rs_scmd;
  logic [47:0] mc_rq_vadr;
  logic [1:0]  mc_rq_size;
  logic [31:0] mc_rq_rtnctl, mc_rs_rtnctl;
  logic [63:0] mc_rq_data, mc_rs_data;

  phold_core dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .gvt(gvt), .rtn_vld(rtn_vld),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic [47:0] exp_vadr[$];
  logic [63:0] exp_data[$];
  logic [13:0] exp_gvt;

  // Event-list view: each step takes the earliest LP, logs it, then reschedules it.
  task automatic build_model(input logic [13:0] init[N]);
    int ts[N];
    int m, lp, k;
    logic [15:0] l;
    exp_vadr.delete();
    exp_data.delete();
    for (int i = 0; i < N; i++) ts[i] = int'(init[i]);
    l = 16'hACE1;
    k = 0;
    while (1) begin
      m = ts[0]; lp = 0;
      for (int i = 1; i < N; i++) if (ts[i] < m) begin m = ts[i]; lp = i; end
      if (m >= END_T) break;
      exp_vadr.push_back(BASE + 48'(8 * N) + 48'(8 * (k % 256)));
      exp_data.push_back(64'((lp << 16) | m));
      ts[lp] = m + 1 + int'(l[3:0]);
      if (ts[lp] > 16383) ts[lp] = 16383;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      k++;
    end
    exp_gvt = 14'(m);
  endtask

  task automatic clear_rs();
    mc_rs_vld = 1'b0; mc_rs_cmd = '0; mc_rs_scmd = '0; mc_rs_rtnctl = '0; mc_rs_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mc_rq_stall = 1'b0; clear_rs();
    repeat (2) @(negedge clk);
    chk("reset_gvt", 64'(gvt), 64'd0);
    chk("reset_rtn_vld", 64'(rtn_vld), 64'd0);
    chk("reset_rq_vld", 64'(mc_rq_vld), 64'd0);
    rst_n = 1'b1;
  endtask

  // order_mode 0: random order/latency; 1: return all reads 7..0 after the last is issued.
  task automatic run(input string tag, input logic [13:0] init[N], input int order_mode,
                     input int stall_first, input int abort_after);
    int pend[$];
    int reads, widx, wc_delay, cyc, stall_cnt, abort_pending, j, idx;
    logic [13:0] prev_gvt;
    logic [47:0] cap_vadr;
    logic [2:0]  cap_cmd;
    logic [31:0] cap_rtnctl;
    logic stall;
    bit done;
    build_model(init);
    do_reset();
    reads = 0; widx = 0; wc_delay = 0; cyc = 0; stall_cnt = 0; abort_pending = 0;
    prev_gvt = 0; done = 0; cap_vadr = '0; cap_cmd = '0; cap_rtnctl = '0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      clear_rs();
      if (cyc > 30000) begin
        n_total++;
        $display("FAIL %s timeout: reads %0d writes %0d of %0d", tag, reads, widx, exp_data.size());
        break;
      end
      if (abort_pending != 0) begin
        rst_n = 1'b0; mc_rq_stall = 1'b0;
        #1;
        chk({tag, "_abort_gvt"}, 64'(gvt), 64'd0);
        chk({tag, "_abort_rq_vld"}, 64'(mc_rq_vld), 64'd0);
        chk({tag, "_abort_rtn_vld"}, 64'(rtn_vld), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mc_rs_vld = 1'b1; mc_rs_cmd = 3'd2; mc_rs_rtnctl = 32'd1; mc_rs_data = '0;
        pend.delete(); reads = 0; widx = 0; wc_delay = 0; prev_gvt = 0; abort_pending = 0;
        continue;
      end
      chk({tag, "_gvt_monotone"}, 64'(gvt >= prev_gvt), 64'd1);
      prev_gvt = gvt;
      if (rtn_vld) begin
        chk({tag, "_reads"}, 64'(reads), 64'(N));
        chk({tag, "_writes"}, 64'(widx), 64'(exp_data.size()));
        chk({tag, "_final_gvt"}, 64'(gvt), 64'(exp_gvt));
        chk({tag, "_final_gvt_ge_end"}, 64'(gvt >= 14'(END_T)), 64'd1);
        mc_rq_stall = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk({tag, "_done_hold"}, {62'd0, rtn_vld, mc_rq_vld}, 64'd2);
          chk({tag, "_done_gvt"}, 64'(gvt), 64'(exp_gvt));
        end
        done = 1;
        continue;
      end
      if (wc_delay > 0) begin
        wc_delay--;
        if (wc_delay == 0) begin
          mc_rs_vld = 1'b1; mc_rs_cmd = 3'd3;
        end else if ($urandom_range(0, 3) == 0) begin
          mc_rs_vld = 1'b1; mc_rs_cmd = 3'd2; mc_rs_rtnctl = 32'd0; mc_rs_data = '0;
        end
      end else if (pend.size() > 0 && ((order_mode == 0 && $urandom_range(0, 1) == 1) ||
                                       (order_mode == 1 && reads == N))) begin
        if (order_mode == 1) idx = pend.pop_back();
        else begin
          j = $urandom_range(0, pend.size() - 1);
          idx = pend[j];
          pend.delete(j);
        end
        mc_rs_vld = 1'b1; mc_rs_cmd = 3'd2; mc_rs_rtnctl = 32'(idx);
        mc_rs_data = {32'hDEAD_BEEF, 18'h3FFFF, init[idx]};
      end else if (reads < N && $urandom_range(0, 7) == 0) begin
        mc_rs_vld = 1'b1; mc_rs_cmd = 3'd3;
      end
      if (stall_first != 0 && reads == 0 && mc_rq_vld[0]) begin
        if (stall_cnt == 0) begin
          cap_vadr = mc_rq_vadr; cap_cmd = mc_rq_cmd; cap_rtnctl = mc_rq_rtnctl;
        end else begin
          chk({tag, "_stall_vadr"}, 64'(mc_rq_vadr), 64'(cap_vadr));
          chk({tag, "_stall_cmd_rtnctl"}, {29'd0, mc_rq_cmd, mc_rq_rtnctl}, {29'd0, cap_cmd, cap_rtnctl});
        end
        stall_cnt++;
        stall = (stall_cnt <= 10);
      end else begin
        stall = ($urandom_range(0, 4) == 0);
      end
      mc_rq_stall = stall;
      if (mc_rq_vld[0] && !stall) begin
        chk({tag, "_rq_fixed"}, {52'd0, mc_rq_scmd, mc_rq_size, mc_rq_flush, mc_rs_stall, 4'd0},
            {52'd0, 4'd0, 2'd3, 1'b0, 1'b0, 4'd0});
        if (mc_rq_cmd == 3'd1) begin
          chk({tag, "_rd_vadr"}, 64'(mc_rq_vadr), 64'(BASE + 48'(8 * reads)));
          chk({tag, "_rd_rtnctl"}, 64'(mc_rq_rtnctl), 64'(reads));
          if (reads < N) pend.push_back(reads);
          reads++;
        end else if (mc_rq_cmd == 3'd2) begin
          if (widx < exp_data.size()) begin
            chk({tag, "_wr_vadr"}, 64'(mc_rq_vadr), 64'(exp_vadr[widx]));
            chk({tag, "_wr_data"}, mc_rq_data, exp_data[widx]);
            chk({tag, "_wr_gvt"}, 64'(gvt), {50'd0, exp_data[widx][13:0]});
          end else begin
            n_total++;
            $display("FAIL %s extra_write: got write %0d expected only %0d", tag, widx, exp_data.size());
          end
          widx++;
          wc_delay = $urandom_range(1, 4);
          if (abort_after != 0 && widx == abort_after) begin
            abort_pending = 1;
            abort_after = 0;
          end
        end else begin
          chk({tag, "_rq_cmd"}, 64'(mc_rq_cmd), 64'd1);
        end
      end
    end
    mc_rq_stall = 1'b0;
    clear_rs();
  endtask

  logic [13:0] init_a [N];
  logic [13:0] init_b [N];
  logic [13:0] init_r [N];

  initial begin
    addr = BASE;
    rst_n = 1'b0;
    mc_rq_stall = 1'b0;
    clear_rs();
    init_a = '{14'd5, 14'd3, 14'd9, 14'd7, 14'd20, 14'd11, 14'd4, 14'd6};
    init_b = '{14'd1500, 14'd1200, 14'd1001, 14'd3000, 14'd1000, 14'd2000, 14'd16383, 14'd1100};

    build_model(init_a);
    chk("model_first_vadr", 64'(exp_vadr[0]), 64'(BASE + 48'd64));
    chk("model_first_data", exp_data[0], 64'h0000_0000_0001_0003);
    chk("model_second_data", exp_data[1], 64'h0000_0000_0006_0004);
    chk("model_third_data", exp_data[2], 64'h0000_0000_0000_0005);
    chk("model_log_wraps", 64'(exp_vadr.size() > 256), 64'd1);
    chk("model_wrap_vadr", 64'(exp_vadr[256]), 64'(BASE + 48'd64));
    build_model(init_b);
    chk("model_nowrite_count", 64'(exp_data.size()), 64'd0);
    chk("model_nowrite_gvt", 64'(exp_gvt), 64'd1000);

    run("basic", init_a, 0, 0, 0);
    run("all_high", init_b, 0, 0, 0);
    run("stall_first", init_a, 0, 1, 0);
    run("reverse", init_a, 1, 0, 0);
    run("abort", init_a, 0, 0, 3);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) init_r[i] = 14'($urandom_range(0, 500));
      run("random", init_r, r, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
